// File: rtl/gp_fifo_arbiter_if.sv
// Requester, downstream-FIFO and status signals of the DDR write-path arbiter.
// slave is the arbiter's view; master is the surrounding environment's view.
interface gp_fifo_arbiter_if;
    logic         req0;
    logic         req1;
    logic         gnt0;
    logic         gnt1;
    logic [30:0]  req0_af_addr_din;
    logic [30:0]  req1_af_addr_din;
    logic         req0_af_wr_en;
    logic         req1_af_wr_en;
    logic [127:0] req0_wdf_din;
    logic [127:0] req1_wdf_din;
    logic [15:0]  req0_wdf_mask_din;
    logic [15:0]  req1_wdf_mask_din;
    logic         req0_wdf_wr_en;
    logic         req1_wdf_wr_en;
    logic         req0_af_full;
    logic         req1_af_full;
    logic         req0_wdf_full;
    logic         req1_wdf_full;
    logic         af_full;
    logic         wdf_full;
    logic [30:0]  af_addr_din;
    logic         af_wr_en;
    logic [127:0] wdf_din;
    logic [15:0]  wdf_mask_din;
    logic         wdf_wr_en;
    logic         proto_err;

    modport slave (
        input  req0, req1,
        input  req0_af_addr_din, req1_af_addr_din,
        input  req0_af_wr_en, req1_af_wr_en,
        input  req0_wdf_din, req1_wdf_din,
        input  req0_wdf_mask_din, req1_wdf_mask_din,
        input  req0_wdf_wr_en, req1_wdf_wr_en,
        input  af_full, wdf_full,
        output gnt0, gnt1,
        output req0_af_full, req1_af_full,
        output req0_wdf_full, req1_wdf_full,
        output af_addr_din, af_wr_en,
        output wdf_din, wdf_mask_din, wdf_wr_en,
        output proto_err
    );

    modport master (
        output req0, req1,
        output req0_af_addr_din, req1_af_addr_din,
        output req0_af_wr_en, req1_af_wr_en,
        output req0_wdf_din, req1_wdf_din,
        output req0_wdf_mask_din, req1_wdf_mask_din,
        output req0_wdf_wr_en, req1_wdf_wr_en,
        output af_full, wdf_full,
        input  gnt0, gnt1,
        input  req0_af_full, req1_af_full,
        input  req0_wdf_full, req1_wdf_full,
        input  af_addr_din, af_wr_en,
        input  wdf_din, wdf_mask_din, wdf_wr_en,
        input  proto_err
    );
endinterface

// File: rtl/gp_fifo_arbiter.sv
// Burst-atomic round-robin arbiter for the shared DDR address/write-data FIFOs.
// Optional protocol checker: define GP_ARB_PROTO_CHECK_EN to build proto_err logic.
module gp_fifo_arbiter #(
    parameter int MAX_BURSTS = 8
) (
    input  logic clk,
    input  logic rst,
    gp_fifo_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    localparam logic [7:0] MAX_B = 8'(MAX_BURSTS);

    state_t     state;
    state_t     state_nx;
    logic       last;
    logic [7:0] burst_cnt;
    logic [7:0] cnt_inc;
    logic       addr_seen;
    logic       beat;
    logic       own0;
    logic       own1;
    logic       af_acc;
    logic       wdf_acc;
    logic       done;
    logic       idle_pt;
    logic       cap;

    assign own0 = (state == GNT0);
    assign own1 = (state == GNT1);

    always_comb begin
        bus.gnt0          = own0;
        bus.gnt1          = own1;
        bus.af_addr_din   = '0;
        bus.af_wr_en      = 1'b0;
        bus.wdf_din       = '0;
        bus.wdf_mask_din  = '1;
        bus.wdf_wr_en     = 1'b0;
        bus.req0_af_full  = 1'b1;
        bus.req0_wdf_full = 1'b1;
        bus.req1_af_full  = 1'b1;
        bus.req1_wdf_full = 1'b1;
        unique case (1'b1)
            own0: begin
                bus.af_addr_din   = bus.req0_af_addr_din;
                bus.af_wr_en      = bus.req0_af_wr_en;
                bus.wdf_din       = bus.req0_wdf_din;
                bus.wdf_mask_din  = bus.req0_wdf_mask_din;
                bus.wdf_wr_en     = bus.req0_wdf_wr_en;
                bus.req0_af_full  = bus.af_full;
                bus.req0_wdf_full = bus.wdf_full;
            end
            own1: begin
                bus.af_addr_din   = bus.req1_af_addr_din;
                bus.af_wr_en      = bus.req1_af_wr_en;
                bus.wdf_din       = bus.req1_wdf_din;
                bus.wdf_mask_din  = bus.req1_wdf_mask_din;
                bus.wdf_wr_en     = bus.req1_wdf_wr_en;
                bus.req1_af_full  = bus.af_full;
                bus.req1_wdf_full = bus.wdf_full;
            end
            default: ;
        endcase
    end

    assign af_acc  = bus.af_wr_en & ~bus.af_full;
    assign wdf_acc = bus.wdf_wr_en & ~bus.wdf_full;
    assign done    = wdf_acc & beat & (addr_seen | af_acc);
    assign idle_pt = (~addr_seen & ~beat) | done;

    always_comb begin
        cnt_inc = burst_cnt;
        if (done && burst_cnt != 8'hFF)
            cnt_inc = burst_cnt + 8'd1;
    end

    assign cap = (cnt_inc >= MAX_B);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                // On a tie the port that did not hold the last grant wins
                if (bus.req0 && (!bus.req1 || last))
                    state_nx = GNT0;
                else if (bus.req1)
                    state_nx = GNT1;
            end
            GNT0: begin
                if (idle_pt) begin
                    if (!bus.req0)
                        state_nx = bus.req1 ? GNT1 : IDLE;
                    else if (bus.req1 && cap)
                        state_nx = GNT1;
                end
            end
            GNT1: begin
                if (idle_pt) begin
                    if (!bus.req1)
                        state_nx = bus.req0 ? GNT0 : IDLE;
                    else if (bus.req0 && cap)
                        state_nx = GNT0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last      <= 1'b1;
            burst_cnt <= '0;
            addr_seen <= 1'b0;
            beat      <= 1'b0;
        end else begin
            state <= state_nx;
            if (state_nx != IDLE && state_nx != state) begin
                last      <= (state_nx == GNT1);
                burst_cnt <= '0;
                addr_seen <= 1'b0;
                beat      <= 1'b0;
            end else if (done) begin
                burst_cnt <= cnt_inc;
                addr_seen <= 1'b0;
                beat      <= 1'b0;
            end else begin
                if (af_acc)
                    addr_seen <= 1'b1;
                if (wdf_acc)
                    beat <= ~beat;
            end
        end
    end

`ifdef GP_ARB_PROTO_CHECK_EN
    logic stray;
    logic seq_err;
    logic proto_q;

    assign stray = (~own0 & (bus.req0_af_wr_en | bus.req0_wdf_wr_en))
                 | (~own1 & (bus.req1_af_wr_en | bus.req1_wdf_wr_en));
    assign seq_err = (wdf_acc & ~beat & ~addr_seen & ~af_acc)
                   | (af_acc & addr_seen);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            proto_q <= 1'b0;
        else if (stray || seq_err)
            proto_q <= 1'b1;
    end

    assign bus.proto_err = proto_q;
`else
    assign bus.proto_err = 1'b0;
`endif
endmodule

// File: tb/tb_gp_fifo_arbiter.sv
// Directed bench for gp_fifo_arbiter: per-cycle vector table plus corner-case
// sequences (single requester, stalled beat, mid-burst drop, reset mid-burst).
module tb_gp_fifo_arbiter;
    localparam int MAXB = 2;
`ifdef GP_ARB_PROTO_CHECK_EN
    localparam logic PC = 1'b1;
`else
    localparam logic PC = 1'b0;
`endif
    localparam logic [30:0]  A0 = 31'h0000_1234;
    localparam logic [30:0]  A1 = 31'h0000_5678;
    localparam logic [127:0] D0 = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
    localparam logic [127:0] D1 = 128'hFEDC_BA98_7654_3210_8899_AABB_CCDD_EEFF;
    localparam logic [15:0]  M0 = 16'h00F0;
    localparam logic [15:0]  M1 = 16'h0F00;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    gp_fifo_arbiter_if bus ();

    gp_fifo_arbiter #(.MAX_BURSTS(MAXB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic r0, r1, a0, w0, a1, w1, aff, wff;
        logic g0, g1, awe, wwe, f0, f1;
    } vec_t;

    vec_t tbl [12];

    task automatic chk1(input string n, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0b exp=%0b", n, act, exp);
        end
    endtask

    task automatic chkw(input string n, input logic [127:0] act,
                        input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", n, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic a0, input logic w0,
                      input logic a1, input logic w1);
        bus.req0_af_wr_en  = a0;
        bus.req0_wdf_wr_en = w0;
        bus.req1_af_wr_en  = a1;
        bus.req1_wdf_wr_en = w1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1);
    end

    initial begin
        bus.req0 = 0;
        bus.req1 = 0;
        bus.req0_af_addr_din  = A0;
        bus.req1_af_addr_din  = A1;
        bus.req0_wdf_din      = D0;
        bus.req1_wdf_din      = D1;
        bus.req0_wdf_mask_din = M0;
        bus.req1_wdf_mask_din = M1;
        bus.af_full  = 0;
        bus.wdf_full = 0;
        wr(0, 0, 0, 0);

        tbl[0]  = 14'b11_00_00_00__00_00_11;
        tbl[1]  = 14'b11_11_00_00__10_11_01;
        tbl[2]  = 14'b11_01_00_00__10_01_01;
        tbl[3]  = 14'b11_11_00_00__10_11_01;
        tbl[4]  = 14'b11_01_00_00__10_01_01;
        tbl[5]  = 14'b11_00_11_00__01_11_10;
        tbl[6]  = 14'b11_00_01_00__01_01_10;
        tbl[7]  = 14'b11_00_11_11__01_11_11;
        tbl[8]  = 14'b11_00_11_00__01_11_10;
        tbl[9]  = 14'b11_00_01_00__01_01_10;
        tbl[10] = 14'b00_00_00_00__10_00_01;
        tbl[11] = 14'b00_10_00_00__00_00_11;

        #2;
        chk1("rst_gnt0", bus.gnt0, 1'b0);
        chk1("rst_gnt1", bus.gnt1, 1'b0);
        chk1("rst_r0_af_full", bus.req0_af_full, 1'b1);
        chk1("rst_r1_wdf_full", bus.req1_wdf_full, 1'b1);
        chkw("rst_mask", 128'(bus.wdf_mask_din), 128'(16'hFFFF));
        chk1("rst_proto", bus.proto_err, 1'b0);
        step();
        rst = 0;

        // Both requesting out of reset: two bursts each, direct handoffs
        for (int i = 0; i < 12; i++) begin
            step();
            bus.req0 = tbl[i].r0;
            bus.req1 = tbl[i].r1;
            wr(tbl[i].a0, tbl[i].w0, tbl[i].a1, tbl[i].w1);
            bus.af_full  = tbl[i].aff;
            bus.wdf_full = tbl[i].wff;
            #1;
            chk1($sformatf("v%0d_gnt0", i), bus.gnt0, tbl[i].g0);
            chk1($sformatf("v%0d_gnt1", i), bus.gnt1, tbl[i].g1);
            chk1($sformatf("v%0d_af_wr_en", i), bus.af_wr_en, tbl[i].awe);
            chk1($sformatf("v%0d_wdf_wr_en", i), bus.wdf_wr_en, tbl[i].wwe);
            chk1($sformatf("v%0d_r0_af_full", i), bus.req0_af_full, tbl[i].f0);
            chk1($sformatf("v%0d_r1_af_full", i), bus.req1_af_full, tbl[i].f1);
            chkw($sformatf("v%0d_addr", i), 128'(bus.af_addr_din),
                 tbl[i].g0 ? 128'(A0) : tbl[i].g1 ? 128'(A1) : 128'd0);
            chkw($sformatf("v%0d_data", i), bus.wdf_din,
                 tbl[i].g0 ? D0 : tbl[i].g1 ? D1 : 128'd0);
            chkw($sformatf("v%0d_mask", i), 128'(bus.wdf_mask_din),
                 tbl[i].g0 ? 128'(M0) : tbl[i].g1 ? 128'(M1) : 128'(16'hFFFF));
        end

        // Single requester: three bursts beyond MAX_BURSTS, then release to IDLE
        step();
        rst = 1;
        wr(0, 0, 0, 0);
        bus.req0 = 0;
        bus.req1 = 0;
        bus.af_full  = 0;
        bus.wdf_full = 0;
        step();
        rst = 0;
        bus.req0 = 1;
        #1;
        chk1("single_idle_gnt0", bus.gnt0, 1'b0);
        step();
        chk1("single_lat_gnt0", bus.gnt0, 1'b1);
        for (int b = 0; b < 3; b++) begin
            bus.req0_af_addr_din = 31'h100 + 31'(b);
            wr(1, 1, 0, 0);
            #1;
            chk1($sformatf("single_b%0d_gnt0_a", b), bus.gnt0, 1'b1);
            chkw($sformatf("single_b%0d_addr", b), 128'(bus.af_addr_din),
                 128'(31'h100 + 31'(b)));
            chkw($sformatf("single_b%0d_data", b), bus.wdf_din, D0);
            step();
            wr(0, 1, 0, 0);
            if (b == 2)
                bus.req0 = 0;
            #1;
            chk1($sformatf("single_b%0d_gnt0_b", b), bus.gnt0, 1'b1);
            chk1($sformatf("single_b%0d_af_wr_en", b), bus.af_wr_en, 1'b0);
            step();
        end
        wr(0, 0, 0, 0);
        #1;
        chk1("single_rel_gnt0", bus.gnt0, 1'b0);
        chk1("single_rel_gnt1", bus.gnt1, 1'b0);
        chk1("single_rel_r0_af_full", bus.req0_af_full, 1'b1);
        bus.req0_af_addr_din = A0;

        // Stalled second beat with req1 waiting; req0 drops mid-burst
        step();
        rst = 1;
        step();
        rst = 0;
        bus.req0 = 1;
        bus.req1 = 1;
        step();
        wr(1, 1, 0, 0);
        #1;
        chk1("stall_start_gnt0", bus.gnt0, 1'b1);
        step();
        bus.req0 = 0;
        bus.wdf_full = 1;
        for (int c = 0; c < 5; c++) begin
            wr(0, 1, 0, c == 0);
            #1;
            chk1($sformatf("stall_c%0d_gnt0", c), bus.gnt0, 1'b1);
            chk1($sformatf("stall_c%0d_gnt1", c), bus.gnt1, 1'b0);
            chk1($sformatf("stall_c%0d_r0_wdf_full", c), bus.req0_wdf_full, 1'b1);
            chk1($sformatf("stall_c%0d_r1_wdf_full", c), bus.req1_wdf_full, 1'b1);
            step();
        end
        bus.wdf_full = 0;
        wr(0, 1, 0, 0);
        #1;
        chk1("stall_done_gnt0", bus.gnt0, 1'b1);
        chk1("stall_done_r0_wdf_full", bus.req0_wdf_full, 1'b0);
        chk1("stall_proto", bus.proto_err, PC);
        step();
        wr(0, 0, 0, 0);
        #1;
        chk1("handoff_gnt1", bus.gnt1, 1'b1);
        chk1("handoff_gnt0", bus.gnt0, 1'b0);
        chk1("handoff_proto_sticky", bus.proto_err, PC);

        // Reset mid-burst while port 1 owns the path
        step();
        wr(0, 0, 1, 1);
        #1;
        chk1("rstmid_pre_gnt1", bus.gnt1, 1'b1);
        rst = 1;
        #1;
        chk1("rstmid_gnt1", bus.gnt1, 1'b0);
        chk1("rstmid_r1_af_full", bus.req1_af_full, 1'b1);
        chk1("rstmid_af_wr_en", bus.af_wr_en, 1'b0);
        chk1("rstmid_proto", bus.proto_err, 1'b0);
        step();
        wr(0, 0, 0, 0);
        rst = 0;
        bus.req0 = 1;
        bus.req1 = 1;
        step();
        chk1("rstmid_tie_gnt0", bus.gnt0, 1'b1);
        chk1("rstmid_tie_gnt1", bus.gnt1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/gp_fifo_arbiter.md
# gp_fifo_arbiter

Two-requester arbiter sharing the single DDR write path (address FIFO plus 128-bit write-data FIFO) between the line engine (port 0) and a second graphics requester such as the frame filler (port 1). Burst-atomic: once a requester owns the path, it keeps it until its current burst finishes. A burst is one address write plus two write-data beats. Grants are round-robin with a bounded hold. Sits between the graphics processor requesters and the memory-controller FIFO inputs.

## Interface
- MAX_BURSTS, 8, bursts a requester may complete per grant while the other port waits (1..255)
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- reqN  in  1  (N=0,1) requester N has writes pending; level, held until its last burst completes
- gntN  out  1  requester N owns the path
- reqN_af_addr_din  in  31  requester N address-FIFO data
- reqN_af_wr_en  in  1  requester N address write
- reqN_wdf_din  in  128  requester N write data
- reqN_wdf_mask_din  in  16  requester N byte mask (1 = masked)
- reqN_wdf_wr_en  in  1  requester N data write
- reqN_af_full  out  1  = af_full when gntN, else 1
- reqN_wdf_full  out  1  = wdf_full when gntN, else 1
- af_full, wdf_full  in  1 each  downstream FIFO full flags
- af_addr_din  out  31  muxed address
- af_wr_en  out  1  muxed address write
- wdf_din  out  128  muxed data
- wdf_mask_din  out  16  muxed mask
- wdf_wr_en  out  1  muxed data write
- proto_err  out  1  sticky protocol-violation flag (see Configuration)

## Operation
- States: IDLE, GNT0, GNT1. gnt0 = (state==GNT0), gnt1 = (state==GNT1).
- IDLE:
  - only req0 → GNT0; only req1 → GNT1.
  - both → grant the port other than `last`. `last` resets to 1, so port 0 wins the first tie.
- Entering GNTn: `last`←n, burst_cnt←0, addr_seen←0, beat←0.
- In GNTn, downstream outputs pass requester n's signals combinationally. Requester n's full outputs mirror downstream. The other requester sees full=1.
- In IDLE: af_wr_en = wdf_wr_en = 0; af_addr_din, wdf_din = 0; wdf_mask_din = 16'hFFFF.
- Acceptance:
  - af_acc = af_wr_en & !af_full
  - wdf_acc = wdf_wr_en & !wdf_full
  - Writes presented while full are not accepted and not counted.
- Burst tracking:
  - addr_seen sets on af_acc. Address and first beat may be accepted in the same cycle.
  - beat toggles on each wdf_acc.
  - Burst completes on the cycle with wdf_acc & beat==1 & (addr_seen | af_acc). On completion: burst_cnt+1 (saturating at 255), addr_seen←0, beat←0.
- Idle point: no burst in flight (addr_seen==0, beat==0), or the burst-completion cycle.
- Release, evaluated only at an idle point in GNTn (o = other port):
  - reqn low & reqo high → GNTo
  - reqn low & reqo low → IDLE
  - reqn high & reqo high & burst_cnt(after increment) ≥ MAX_BURSTS → GNTo
  - otherwise stay GNTn
- reqn dropping mid-burst does not release; the grant is held until the burst completes.
- Direct GNTn→GNTo handoff takes no IDLE cycle.

## Timing
- Reset values: state IDLE, `last` 1, gnt0/gnt1 0, reqN_af_full/reqN_wdf_full 1, proto_err 0, downstream outputs as in IDLE.
- Grant latency: reqN sampled high in IDLE → gntN high the next cycle. The requester may write in that same cycle.
- Datapath: zero-latency combinational mux. No registers on addr, data or mask.
- Release: the state change registers on the completion/idle-point edge. The new owner's writes pass from the following cycle.
- Downstream full mid-burst: grant is held indefinitely; no timeout.
- Reset asserted mid-burst: immediate return to IDLE. A partial burst already in the FIFOs is not repaired; upstream reset is expected to flush.

## Configuration
- GP_ARB_PROTO_CHECK_EN defined: proto_err sets (sticky until rst) when either of these occurs:
  - the granted requester gets wdf_acc with beat==0 and neither addr_seen nor af_acc;
  - af_acc while addr_seen is already 1.
  
  Also sets on any wr_en from a non-granted requester.
- Undefined: proto_err tied 0 and no checker logic is generated. Arbitration behaviour is identical in both builds.

## Test plan
- Single requester: req0=1, 3 bursts with af and beat 0 in one cycle, fulls low → gnt0 the cycle after req0. af_addr_din/wdf_din match req0. Release to IDLE after the 3rd burst once req0 drops.
- Simultaneous req0=req1=1 out of reset, MAX_BURSTS=2 → GNT0 for 2 bursts, GNT1 for 2 bursts, GNT0 again. No IDLE cycle between grants. req1_af_full=1 throughout GNT0.
- wdf_full asserted between beat 0 and beat 1 for 5 cycles while req1 waits → gnt0 held. Second beat accepted after full drops, then handoff to GNT1.
- req0 drops after address and beat 0 accepted → grant held until beat 1 accepted, then IDLE (req1=0) or GNT1.
- rst asserted mid-burst in GNT1 → gnt1=0 and req1_af_full=1 immediately. After release with both requesting, port 0 is granted first.
- GP_ARB_PROTO_CHECK_EN: req1 pulses wdf_wr_en while gnt0 → proto_err=1 and stays 1 until rst. Without the macro, proto_err stays 0.
